rc4_phase_sched: RTL and testbench
==================================

Name: rc4_phase_sched

Overview:
- Top-level sequencer for the RC4 key-search datapath.
- Runs three phase engines in order for each candidate key: init (S[i]=i), shuffle (key-scheduled swap), decrypt/check.
- Owns the single S-memory port and muxes address/data/wren from whichever engine is active.
- On a bad key it increments the key and restarts from init, until success or KEY_MAX is exhausted.

Parameters:
- KEY_W, 24, candidate key width.
- KEY_MAX, 24'h3FFFFF, last key tried (inclusive).
- ADDR_W, 8, S-memory address/data width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- go  in  1  one-cycle pulse; starts a search from key_start
- abort  in  1  synchronous; returns the block to IDLE
- key_start  in  KEY_W  first key to try; sampled on go
- key  out  KEY_W  current candidate key, fed to the shuffle and decrypt engines
- init_start, shuf_start, dec_start  out  1 each  level enables; held high for the whole phase
- init_finished, shuf_finished, dec_finished  in  1 each  one-cycle completion pulses
- dec_key_ok  in  1  valid only while dec_finished=1; 1 means the decrypted text is legal
- init_addr, shuf_addr, dec_addr  in  ADDR_W each  engine S-memory addresses
- init_data, shuf_data, dec_data  in  ADDR_W each  engine S-memory write data
- init_wren, shuf_wren, dec_wren  in  1 each  engine S-memory write enables
- s_addr  out  ADDR_W  S-memory address
- s_data  out  ADDR_W  S-memory write data
- s_wren  out  1  S-memory write enable
- busy  out  1  high in INIT, SHUF, DEC and NEXT
- found  out  1  sticky success flag
- failed  out  1  sticky exhaustion flag

Behaviour:
- Reset (reset=0, async): state=IDLE; key=0; all *_start=0; found=0; failed=0; busy=0; s_addr=0; s_data=0; s_wren=0.
- States: IDLE, INIT, SHUF, DEC, NEXT, DONE.
- IDLE: on go, key<=key_start, found<=0, failed<=0, go to INIT.
- INIT: init_start=1. On init_finished, go to SHUF.
- SHUF: shuf_start=1. On shuf_finished, go to DEC.
- DEC: dec_start=1. On dec_finished:
  - dec_key_ok=1: found<=1, go to DONE.
  - key==KEY_MAX: failed<=1, go to DONE.
  - otherwise: key<=key+1, go to NEXT.
- NEXT: one idle cycle with all starts low, so engines that self-clear on finished are back at their reset state; then go to INIT.
- DONE: all starts low; found/failed held. On go, behave exactly as IDLE does (key reload, flags cleared).
- *_start is a registered decode of state: it rises one cycle after the state is entered and falls on the edge after the finished pulse is sampled. At most one *_start is ever high.
- A finished pulse from an engine that is not the active phase is ignored.
- go while busy=1 is ignored.
- abort (any state, highest priority over go and finished): go to IDLE next edge, starts drop, key held, found/failed cleared.
- Memory mux is combinational from the registered state:
  - INIT selects init_*; SHUF selects shuf_*; DEC selects dec_*.
  - IDLE, NEXT and DONE drive s_addr=0, s_data=0, s_wren=0.
  - s_wren is never high outside the active phase.
- key increments by exactly 1 with no wrap; exhaustion is checked before incrementing, so KEY_MAX itself is tried.
- dec_key_ok is sampled only in the cycle where dec_finished=1.

Decomposition:
- Package rc4_pkg holds:
  - the phase_t enum {IDLE, INIT, SHUF, DEC, NEXT, DONE};
  - the constants KEY_W, ADDR_W, KEY_MAX.
- Sub-module s_mem_mux is natural: a 3:1 mux with a select input and an idle-zero output, reused by the later dual-RAM (message/result) controller.

Test Plan:
- Reset mid-DEC (reset=0 asynchronously): all outputs return to reset values immediately; state=IDLE; s_wren=0 in the same cycle.
- go with key_start=0x000010, first decrypt passes (dec_key_ok=1): phase order INIT→SHUF→DEC with one-hot starts; found=1, key=0x000010, busy=0, failed=0.
- key_start=0x000005, ok on the third attempt: key steps 5→6→7; each attempt has one NEXT cycle with no start high; found=1, key=0x000007.
- key_start=KEY_MAX-1, both attempts fail: failed=1, found=0, key=KEY_MAX; a later go with key_start=0 restarts the search cleanly.
- Mux check: in INIT, drive init_addr=0x3C, init_wren=1 and shuf_wren=1 → s_addr=0x3C, s_wren=1; during NEXT any engine wren → s_wren=0.
- Robustness, three checks:
  - spurious shuf_finished during INIT → no transition;
  - go while busy → no key reload;
  - abort in SHUF → IDLE next cycle, shuf_start=0.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer and its memory mux.
package rc4_pkg;

  localparam int KEY_W  = 24;
  localparam int ADDR_W = 8;
  localparam logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    SHUF = 3'd2,
    DEC  = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } phase_t;

  // Memory-mux source select; SEL_NONE forces the shared port to all zeros.
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_C    = 2'd3;

endpackage

// File: rtl/s_mem_mux.sv
// 3:1 single-port memory request mux; an idle select drives address, data and write enable to zero.
module s_mem_mux
  import rc4_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   sel_i,
  input  logic [W-1:0] a_addr_i,
  input  logic [W-1:0] a_data_i,
  input  logic         a_wren_i,
  input  logic [W-1:0] b_addr_i,
  input  logic [W-1:0] b_data_i,
  input  logic         b_wren_i,
  input  logic [W-1:0] c_addr_i,
  input  logic [W-1:0] c_data_i,
  input  logic         c_wren_i,
  output logic [W-1:0] addr_o,
  output logic [W-1:0] data_o,
  output logic         wren_o
);

  always_comb begin
    addr_o = '0;
    data_o = '0;
    wren_o = 1'b0;
    case (sel_i)
      SEL_A: begin
        addr_o = a_addr_i;
        data_o = a_data_i;
        wren_o = a_wren_i;
      end
      SEL_B: begin
        addr_o = b_addr_i;
        data_o = b_data_i;
        wren_o = b_wren_i;
      end
      SEL_C: begin
        addr_o = c_addr_i;
        data_o = c_data_i;
        wren_o = c_wren_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_phase_sched.sv
// RC4 key-search sequencer: runs init/shuffle/decrypt per candidate key and owns the S-memory port.
// Engine handshake: *_start is a level held for the whole phase; the engine answers with a one-cycle *_finished.
module rc4_phase_sched
  import rc4_pkg::*;
#(
  parameter int                  KEY_W   = rc4_pkg::KEY_W,
  parameter logic [KEY_W-1:0]    KEY_MAX = rc4_pkg::KEY_MAX,
  parameter int                  ADDR_W  = rc4_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  input  logic [KEY_W-1:0]  key_start,
  output logic [KEY_W-1:0]  key,
  output logic              init_start,
  output logic              shuf_start,
  output logic              dec_start,
  input  logic              init_finished,
  input  logic              shuf_finished,
  input  logic              dec_finished,
  input  logic              dec_key_ok,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] shuf_addr,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [ADDR_W-1:0] init_data,
  input  logic [ADDR_W-1:0] shuf_data,
  input  logic [ADDR_W-1:0] dec_data,
  input  logic              init_wren,
  input  logic              shuf_wren,
  input  logic              dec_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [ADDR_W-1:0] s_data,
  output logic              s_wren,
  output logic              busy,
  output logic              found,
  output logic              failed,
  output phase_t            phase_o
);

  phase_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             found_q, found_d;
  logic             failed_q, failed_d;
  logic             init_start_q, shuf_start_q, dec_start_q;
  logic [1:0]       mux_sel;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    found_d  = found_q;
    failed_d = failed_q;
    if (abort) begin
      state_d  = IDLE;
      found_d  = 1'b0;
      failed_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (go) begin
            state_d  = INIT;
            key_d    = key_start;
            found_d  = 1'b0;
            failed_d = 1'b0;
          end
        end
        INIT: if (init_finished) state_d = SHUF;
        SHUF: if (shuf_finished) state_d = DEC;
        DEC: begin
          // Exhaustion is tested before incrementing so KEY_MAX itself gets a full attempt.
          if (dec_finished) begin
            if (dec_key_ok) begin
              found_d = 1'b1;
              state_d = DONE;
            end else if (key_q == KEY_MAX) begin
              failed_d = 1'b1;
              state_d  = DONE;
            end else begin
              key_d   = key_q + 1'b1;
              state_d = NEXT;
            end
          end
        end
        NEXT:    state_d = INIT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Starts rise a cycle after the phase is entered and drop on the edge that leaves it,
  // which keeps them one-hot and leaves NEXT with every start low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      key_q        <= '0;
      found_q      <= 1'b0;
      failed_q     <= 1'b0;
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      dec_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      found_q      <= found_d;
      failed_q     <= failed_d;
      init_start_q <= (state_q == INIT) && (state_d == INIT);
      shuf_start_q <= (state_q == SHUF) && (state_d == SHUF);
      dec_start_q  <= (state_q == DEC)  && (state_d == DEC);
    end
  end

  always_comb begin
    mux_sel = SEL_NONE;
    case (state_q)
      INIT:    mux_sel = SEL_A;
      SHUF:    mux_sel = SEL_B;
      DEC:     mux_sel = SEL_C;
      default: mux_sel = SEL_NONE;
    endcase
  end

  s_mem_mux #(.W(ADDR_W)) u_s_mem_mux (
    .sel_i    (mux_sel),
    .a_addr_i (init_addr),
    .a_data_i (init_data),
    .a_wren_i (init_wren),
    .b_addr_i (shuf_addr),
    .b_data_i (shuf_data),
    .b_wren_i (shuf_wren),
    .c_addr_i (dec_addr),
    .c_data_i (dec_data),
    .c_wren_i (dec_wren),
    .addr_o   (s_addr),
    .data_o   (s_data),
    .wren_o   (s_wren)
  );

  assign key        = key_q;
  assign init_start = init_start_q;
  assign shuf_start = shuf_start_q;
  assign dec_start  = dec_start_q;
  assign found      = found_q;
  assign failed     = failed_q;
  assign busy       = (state_q == INIT) || (state_q == SHUF) ||
                      (state_q == DEC)  || (state_q == NEXT);
  assign phase_o    = state_q;

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Bench for rc4_phase_sched: randomized engine models, result scoreboard and per-cycle port checks.
module tb_rc4_phase_sched;
  import rc4_pkg::*;

  localparam int RW = KEY_W + 2;
  localparam int WAIT_MAX = 3000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic              go, abort;
  logic [KEY_W-1:0]  key_start, key;
  logic              init_start, shuf_start, dec_start;
  logic              init_finished, shuf_finished, dec_finished, dec_key_ok;
  logic [ADDR_W-1:0] init_addr, shuf_addr, dec_addr;
  logic [ADDR_W-1:0] init_data, shuf_data, dec_data;
  logic              init_wren, shuf_wren, dec_wren;
  logic [ADDR_W-1:0] s_addr, s_data;
  logic              s_wren, busy, found, failed;
  phase_t            phase_o;

  // Auto engine models (a_*) or directed overrides (m_*)
  logic              man_mode;
  logic [ADDR_W-1:0] a_addr[3], a_data[3], m_addr[3], m_data[3];
  logic [2:0]        a_wren, m_wren, a_fin, m_fin;
  logic              a_ok, m_ok;
  logic              has_good;
  logic [KEY_W-1:0]  good_key;

  int checks = 0;
  int errors = 0;
  int next_total = 0;
  logic [RW-1:0] exp_q[$];

  assign init_addr     = man_mode ? m_addr[0] : a_addr[0];
  assign shuf_addr     = man_mode ? m_addr[1] : a_addr[1];
  assign dec_addr      = man_mode ? m_addr[2] : a_addr[2];
  assign init_data     = man_mode ? m_data[0] : a_data[0];
  assign shuf_data     = man_mode ? m_data[1] : a_data[1];
  assign dec_data      = man_mode ? m_data[2] : a_data[2];
  assign init_wren     = man_mode ? m_wren[0] : a_wren[0];
  assign shuf_wren     = man_mode ? m_wren[1] : a_wren[1];
  assign dec_wren      = man_mode ? m_wren[2] : a_wren[2];
  assign init_finished = man_mode ? m_fin[0]  : a_fin[0];
  assign shuf_finished = man_mode ? m_fin[1]  : a_fin[1];
  assign dec_finished  = man_mode ? m_fin[2]  : a_fin[2];
  assign dec_key_ok    = man_mode ? m_ok      : a_ok;

  rc4_phase_sched dut (
    .clock(clock), .reset(reset), .go(go), .abort(abort),
    .key_start(key_start), .key(key),
    .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
    .init_finished(init_finished), .shuf_finished(shuf_finished),
    .dec_finished(dec_finished), .dec_key_ok(dec_key_ok),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren),
    .busy(busy), .found(found), .failed(failed), .phase_o(phase_o)
  );

  // ---------------- engine models ----------------
  // Each engine finishes 1..4 cycles after its start is seen; other engines fire stray finishes.
  initial begin
    int lat;
    logic [2:0] act;
    lat = 0;
    a_fin = '0; a_ok = 1'b0; a_wren = '0;
    for (int i = 0; i < 3; i++) begin a_addr[i] = '0; a_data[i] = '0; end
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) begin
        a_addr[i] = 8'($urandom_range(0, 255));
        a_data[i] = 8'($urandom_range(0, 255));
      end
      a_wren = 3'($urandom_range(0, 7));
      a_fin  = '0;
      a_ok   = 1'b0;
      act    = {dec_start, shuf_start, init_start};
      if (act != 3'b000) begin
        if (lat == 0) lat = $urandom_range(1, 4);
        else begin
          lat--;
          if (lat == 0) begin
            a_fin = act;
            if (dec_start) a_ok = has_good && (key == good_key);
          end else if ($urandom_range(0, 3) == 0) begin
            a_fin = ~act & 3'(1 << $urandom_range(0, 2));
          end
        end
      end else begin
        lat = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic prev;
    logic [RW-1:0] exp;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && (found || failed) && !prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected completion found=%0b failed=%0b key=%h", found, failed, key);
        end else begin
          exp = exp_q.pop_front();
          if ({found, failed, key} !== exp) begin
            errors++;
            $display("FAIL result: got found=%0b failed=%0b key=%h, expected found=%0b failed=%0b key=%h",
                     found, failed, key, exp[RW-1], exp[RW-2], exp[KEY_W-1:0]);
          end
        end
      end
      prev = found || failed;
    end
  end

  // ---------------- per-cycle port rules ----------------
  initial begin
    logic [2*ADDR_W:0] e;
    logic is_busy;
    logic ok;
    forever begin
      @(negedge clock);
      if (reset) begin
        e = '0;
        case (phase_o)
          INIT: e = {init_addr, init_data, init_wren};
          SHUF: e = {shuf_addr, shuf_data, shuf_wren};
          DEC:  e = {dec_addr, dec_data, dec_wren};
          default: e = '0;
        endcase
        is_busy = (phase_o == INIT) || (phase_o == SHUF) || (phase_o == DEC) || (phase_o == NEXT);
        if (phase_o == NEXT) next_total++;
        ok = ({s_addr, s_data, s_wren} == e) &&
             ($countones({init_start, shuf_start, dec_start}) <= 1) &&
             !(phase_o == NEXT && (init_start || shuf_start || dec_start)) &&
             (busy == is_busy);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL port_rules: phase=%0d s=%h/%h/%0b expected %h/%h/%0b starts=%b busy=%0b",
                   phase_o, s_addr, s_data, s_wren, e[2*ADDR_W:ADDR_W+1], e[ADDR_W:1], e[0],
                   {init_start, shuf_start, dec_start}, busy);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic pulse_go(input logic [KEY_W-1:0] start);
    key_start = start;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pulse_fin(input logic [2:0] f, input logic ok);
    m_fin = f;
    m_ok  = ok;
    tick();
    m_fin = '0;
    m_ok  = 1'b0;
  endtask

  // Reference: the search ends at the first good key in [start, KEY_MAX], else fails at KEY_MAX.
  task automatic run_search(input logic [KEY_W-1:0] start, input logic hg, input logic [KEY_W-1:0] gk);
    logic [RW-1:0] exp;
    int n;
    has_good = hg;
    good_key = gk;
    if (hg && (gk >= start) && (gk <= KEY_MAX)) exp = {1'b1, 1'b0, gk};
    else exp = {1'b0, 1'b1, KEY_MAX};
    exp_q.push_back(exp);
    tick();
    pulse_go(start);
    n = 0;
    while (!(found || failed) && n < WAIT_MAX) begin
      tick();
      n++;
    end
    checks++;
    if (n >= WAIT_MAX) begin
      errors++;
      $display("FAIL search_timeout: no completion after %0d cycles from key %h", n, start);
    end
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    logic [KEY_W-1:0] st, gk;
    logic hg;
    reset = 1'b0; go = 1'b0; abort = 1'b0; key_start = '0;
    man_mode = 1'b0; m_fin = '0; m_ok = 1'b0; m_wren = '0;
    has_good = 1'b0; good_key = '0;
    for (int i = 0; i < 3; i++) begin m_addr[i] = '0; m_data[i] = '0; end

    repeat (3) @(posedge clock);
    #1;
    chk("reset_phase", 32'(phase_o), 32'(IDLE));
    chk("reset_key", 32'(key), 32'h0);
    chk("reset_outs", {24'h0, init_start, shuf_start, dec_start, found, failed, busy, s_wren, 1'b0}, 32'h0);
    chk("reset_mem", {16'h0, s_addr, s_data}, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // first key passes
    n0 = next_total;
    run_search(24'h000010, 1'b1, 24'h000010);
    chk("t1_key", 32'(key), 32'h10);
    chk("t1_flags", {29'h0, found, failed, busy}, 32'b100);
    chk("t1_no_next", 32'(next_total - n0), 32'd0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_found", {30'h0, found, failed}, 32'h0);
    chk("abort_done_key", 32'(key), 32'h10);

    // third attempt passes: two NEXT cycles
    n0 = next_total;
    run_search(24'h000005, 1'b1, 24'h000007);
    chk("t2_key", 32'(key), 32'h7);
    chk("t2_next_cycles", 32'(next_total - n0), 32'd2);

    // exhaustion, then clean restart
    run_search(KEY_MAX - 1'b1, 1'b0, '0);
    chk("t3_flags", {30'h0, found, failed}, 32'b01);
    chk("t3_key", 32'(key), 32'(KEY_MAX));
    run_search(24'h000000, 1'b1, 24'h000002);
    chk("t3_restart", {7'h0, found, key}, {8'h1, 24'h000002});

    // randomized searches
    repeat (10) begin
      if ($urandom_range(0, 2) == 0) begin
        st = KEY_MAX - KEY_W'($urandom_range(0, 3));
        hg = 1'($urandom_range(0, 1));
        gk = st + KEY_W'($urandom_range(0, 5));
      end else begin
        st = KEY_W'($urandom_range(0, 32'(KEY_MAX) - 10));
        hg = 1'b1;
        gk = st + KEY_W'($urandom_range(0, 4));
      end
      run_search(st, hg, gk);
    end

    // directed robustness and mux checks
    man_mode = 1'b1;
    tick();
    pulse_go(24'h000100);
    chk("m_enter_init", 32'(phase_o), 32'(INIT));
    tick();
    chk("m_init_start", 32'(init_start), 32'h1);
    pulse_fin(3'b010, 1'b0);
    chk("spurious_fin_phase", 32'(phase_o), 32'(INIT));
    chk("spurious_fin_start", 32'(init_start), 32'h1);
    pulse_go(24'h000999);
    chk("go_busy_key", 32'(key), 32'h100);
    m_addr[0] = 8'h3C;
    m_wren    = 3'b011;
    #1;
    chk("mux_init_addr", 32'(s_addr), 32'h3C);
    chk("mux_init_wren", 32'(s_wren), 32'h1);
    m_wren = '0;
    pulse_fin(3'b001, 1'b0);
    chk("m_enter_shuf", 32'(phase_o), 32'(SHUF));
    tick();
    chk("m_shuf_start", 32'(shuf_start), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_phase", 32'(phase_o), 32'(IDLE));
    chk("abort_outs", {29'h0, shuf_start, busy, found}, 32'h0);
    chk("abort_key", 32'(key), 32'h100);

    // bad key -> NEXT with wren masked, then async reset in DEC
    pulse_go(24'h000200);
    pulse_fin(3'b001, 1'b0);
    pulse_fin(3'b010, 1'b0);
    pulse_fin(3'b100, 1'b0);
    m_wren = 3'b111;
    #1;
    chk("next_phase", 32'(phase_o), 32'(NEXT));
    chk("next_wren", 32'(s_wren), 32'h0);
    chk("next_key", 32'(key), 32'h201);
    m_wren = '0;
    tick();
    pulse_fin(3'b001, 1'b0);
    pulse_fin(3'b010, 1'b0);
    tick();
    chk("m_dec_start", 32'(dec_start), 32'h1);
    m_wren = 3'b100;
    #1;
    chk("dec_wren", 32'(s_wren), 32'h1);
    reset = 1'b0;
    #1;
    chk("async_reset_wren", 32'(s_wren), 32'h0);
    chk("async_reset_phase", 32'(phase_o), 32'(IDLE));
    chk("async_reset_outs", {24'h0, init_start, shuf_start, dec_start, found, failed, busy, 2'b00}, 32'h0);
    chk("async_reset_key", 32'(key), 32'h0);
    m_wren = '0;
    @(negedge clock);
    reset = 1'b1;

    man_mode = 1'b0;
    run_search(24'h000030, 1'b1, 24'h000031);
    chk("final_key", 32'(key), 32'h31);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
